// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM, and registered
// press/release/long-press pulses plus a saturating hold-duration count.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
    parameter int unsigned LONG_PRESS_CYCLES = 200_000_000,
    parameter bit          BTN_ACTIVE_LOW    = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        btn_raw_i,
    output logic        btn_level_o,
    output logic        press_pulse_o,
    output logic        release_pulse_o,
    output logic        long_press_o,
    output logic [31:0] hold_cycles_o
);

    localparam int unsigned     CNT_W     = 32;
    localparam logic [CNT_W-1:0] DCNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    logic             btn;
    logic             sync_meta;
    logic             sync;

    state_e           state;
    state_e           state_next;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] dcnt_next;
    logic [CNT_W-1:0] hold;
    logic [CNT_W-1:0] hold_next;
    logic [CNT_W-1:0] hold_inc;
    logic             level;
    logic             level_next;
    logic             press;
    logic             press_next;
    logic             release_q;
    logic             release_next;
    logic             long_q;
    logic             long_next;

    // Normalise pad polarity so 1 always means pressed.
    assign btn = btn_raw_i ^ BTN_ACTIVE_LOW;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync      <= sync_meta;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            dcnt      <= '0;
            hold      <= '0;
            level     <= 1'b0;
            press     <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state     <= state_next;
            dcnt      <= dcnt_next;
            hold      <= hold_next;
            level     <= level_next;
            press     <= press_next;
            release_q <= release_next;
            long_q    <= long_next;
        end
    end

    // Next-state, counters and pulse decode; outputs are the registered copies.
    always_comb begin
        state_next   = state;
        dcnt_next    = dcnt;
        hold_next    = hold;
        press_next   = 1'b0;
        release_next = 1'b0;
        long_next    = 1'b0;
        hold_inc     = (hold == HOLD_MAX) ? hold : hold + CNT_W'(1);

        case (state)
            IDLE: begin
                if (sync) begin
                    state_next = PRESS_WAIT;
                    dcnt_next  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_next = IDLE;
                end else if (dcnt == DCNT_LAST) begin
                    state_next = PRESSED;
                    hold_next  = '0;
                    press_next = 1'b1;
                end else begin
                    dcnt_next = dcnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                hold_next = hold_inc;
                long_next = (hold == HOLD_LAST);
                if (!sync) begin
                    state_next = RELEASE_WAIT;
                    dcnt_next  = '0;
                end
            end
            RELEASE_WAIT: begin
                hold_next = hold_inc;
                long_next = (hold == HOLD_LAST);
                if (sync) begin
                    state_next = PRESSED;
                end else if (dcnt == DCNT_LAST) begin
                    // Release pulse owns this cycle; the press is over.
                    state_next   = IDLE;
                    release_next = 1'b1;
                    long_next    = 1'b0;
                end else begin
                    dcnt_next = dcnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
    end

    assign btn_level_o     = level;
    assign press_pulse_o   = press;
    assign release_pulse_o = release_q;
    assign long_press_o    = long_q;
    assign hold_cycles_o   = hold;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: directed scenarios plus random button runs, checked
// against a run-length reference model on an active-high and an active-low DUT.
module tb_button_conditioner;

    localparam int unsigned D = 4;
    localparam int unsigned L = 10;
    localparam longint     HOLD_SAT = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn = 1'b0;
    logic        btn_al;

    logic        lvl_a, press_a, rel_a, long_a;
    logic [31:0] hold_a;
    logic        lvl_b, press_b, rel_b, long_b;
    logic [31:0] hold_b;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit     h1, h2;
    bit     m_lvl;
    int     m_run;
    longint m_hold;
    bit     m_press, m_rel, m_long;

    int press_at, rel_at, long_at, cnt;

    assign btn_al = ~btn;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .BTN_ACTIVE_LOW(1'b0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .btn_raw_i(btn),
        .btn_level_o(lvl_a), .press_pulse_o(press_a), .release_pulse_o(rel_a),
        .long_press_o(long_a), .hold_cycles_o(hold_a)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .BTN_ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk_i(clk), .rst_ni(rst_n), .btn_raw_i(btn_al),
        .btn_level_o(lvl_b), .press_pulse_o(press_b), .release_pulse_o(rel_b),
        .long_press_o(long_b), .hold_cycles_o(hold_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        h1 = 1'b0; h2 = 1'b0;
        m_lvl = 1'b0; m_run = 0; m_hold = 0;
        m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
    endtask

    // A level change is accepted once the synchronised input has disagreed
    // with the accepted level for D+1 consecutive edges.
    task automatic model_edge(input bit r);
        bit     s;
        bit     was;
        longint hb;
        s   = h2;
        was = m_lvl;
        hb  = m_hold;
        m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
        if (was) m_hold = (m_hold >= HOLD_SAT) ? HOLD_SAT : m_hold + 1;
        if (s != m_lvl) m_run++; else m_run = 0;
        if (m_run == int'(D) + 1) begin
            m_run = 0;
            if (!was) begin
                m_lvl = 1'b1; m_press = 1'b1; m_hold = 0;
            end else begin
                m_lvl = 1'b0; m_rel = 1'b1;
            end
        end
        m_long = was && (hb == longint'(L) - 1) && !m_rel;
        h2 = h1;
        h1 = r;
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_level_hi"},   32'(lvl_a),   32'(m_lvl));
        check({tag, "_press_hi"},   32'(press_a), 32'(m_press));
        check({tag, "_release_hi"}, 32'(rel_a),   32'(m_rel));
        check({tag, "_long_hi"},    32'(long_a),  32'(m_long));
        check({tag, "_hold_hi"},    hold_a,       32'(m_hold));
        check({tag, "_level_lo"},   32'(lvl_b),   32'(m_lvl));
        check({tag, "_press_lo"},   32'(press_b), 32'(m_press));
        check({tag, "_release_lo"}, 32'(rel_b),   32'(m_rel));
        check({tag, "_long_lo"},    32'(long_b),  32'(m_long));
        check({tag, "_hold_lo"},    hold_b,       32'(m_hold));
    endtask

    task automatic step(input string tag, input bit b);
        btn = b;
        @(posedge clk);
        model_edge(b);
        #1;
        compare_all(tag);
    endtask

    initial begin
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step("idle", 1'b0);

        // Clean press
        press_at = 0;
        for (int i = 1; i <= 12; i++) begin
            step("clean_press", 1'b1);
            if (press_a === 1'b1 && press_at == 0) press_at = i;
        end
        check("clean_press_latency", 32'(press_at), 32'd7);

        // Clean release
        rel_at = 0;
        for (int i = 1; i <= 12; i++) begin
            step("clean_release", 1'b0);
            if (rel_a === 1'b1 && rel_at == 0) rel_at = i;
        end
        check("clean_release_latency", 32'(rel_at), 32'd7);

        // Press bounce: high 2, low 1, then steady high
        cnt = 0;
        step("press_bounce", 1'b1);
        if (press_a === 1'b1) cnt++;
        step("press_bounce", 1'b1);
        if (press_a === 1'b1) cnt++;
        step("press_bounce", 1'b0);
        if (press_a === 1'b1) cnt++;
        press_at = 0;
        for (int i = 1; i <= 12; i++) begin
            step("press_bounce", 1'b1);
            if (press_a === 1'b1) begin
                cnt++;
                if (press_at == 0) press_at = i;
            end
        end
        check("bounce_press_latency", 32'(press_at), 32'd7);
        check("bounce_press_count", 32'(cnt), 32'd1);

        // Release bounce: low 2, high again, then steady low
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            step("release_bounce", (i < 2) ? 1'b0 : 1'b1);
            if (rel_a === 1'b1 || lvl_a !== 1'b1) cnt++;
        end
        check("release_bounce_glitch_free", 32'(cnt), 32'd0);
        rel_at = 0;
        for (int i = 1; i <= 12; i++) begin
            step("release_bounce", 1'b0);
            if (rel_a === 1'b1 && rel_at == 0) rel_at = i;
        end
        check("bounce_release_latency", 32'(rel_at), 32'd7);

        // Long press
        press_at = 0; long_at = 0; cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            step("long_press", 1'b1);
            if (press_a === 1'b1 && press_at == 0) press_at = i;
            if (long_a === 1'b1) begin
                cnt++;
                if (long_at == 0) long_at = i;
            end
        end
        check("long_press_delay", 32'(long_at - press_at), 32'd10);
        check("long_press_count", 32'(cnt), 32'd1);
        for (int i = 0; i < 12; i++) step("long_release", 1'b0);

        // Reset mid-press, landing on the cycle the press pulse is high
        for (int i = 0; i < 7; i++) step("pre_reset", 1'b1);
        check("pre_reset_press_seen", 32'(press_a), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all("reset_async");
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        press_at = 0;
        for (int i = 1; i <= 12; i++) begin
            step("post_reset", 1'b1);
            if (press_a === 1'b1 && press_at == 0) press_at = i;
        end
        check("post_reset_press_latency", 32'(press_at), 32'd7);
        for (int i = 0; i < 12; i++) step("post_reset_release", 1'b0);

        // Random runs of bouncing and steady levels
        for (int r = 0; r < 300; r++) begin
            bit lv;
            int len;
            lv  = 1'($urandom_range(0, 1));
            len = (($urandom_range(0, 3)) == 0) ? int'($urandom_range(8, 25))
                                                : int'($urandom_range(1, 6));
            for (int k = 0; k < len; k++) step("random", lv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions a raw mechanical push-button input into clean, single-cycle events for the downstream timeout counter.
- Synchronises the asynchronous pad input and rejects bounce with a debounce state machine.
- Emits a one-cycle press pulse, which drives the timeout counter's enable, plus release and long-press pulses and a hold-duration count.
- Runs on the same 100 MHz (10 ns) system clock as the timeout counter.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, number of stable cycles required to accept a level change (10 ms); legal range 2..2^32-1.
- LONG_PRESS_CYCLES, 200_000_000, number of debounced hold cycles before long_press_o fires (2 s); must be >= 1.
- BTN_ACTIVE_LOW, 0, 1 means the raw pad reads 0 when pressed, so the input is inverted before the synchroniser.

Ports:
- clk_i  input  1  system clock, 10 ns period
- rst_ni  input  1  asynchronous, active-low reset
- btn_raw_i  input  1  raw asynchronous button pad
- btn_level_o  output  1  debounced button state, 1 = pressed
- press_pulse_o  output  1  one-cycle pulse on an accepted press; drives the timeout counter enable
- release_pulse_o  output  1  one-cycle pulse on an accepted release
- long_press_o  output  1  one-cycle pulse when the hold reaches LONG_PRESS_CYCLES
- hold_cycles_o  output  32  debounced hold duration, saturating at 2^32-1

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - Both synchroniser flops, the debounce counter and the hold counter clear to 0.
  - State goes to IDLE.
  - All outputs are 0 for as long as reset is held.
- Synchroniser:
  - btn = btn_raw_i XOR BTN_ACTIVE_LOW passes through 2 flops; the FSM sees only the second flop, sync.
  - No other logic touches btn_raw_i.
- IDLE:
  - btn_level_o=0.
  - sync=1 -> PRESS_WAIT, dcnt<=0.
- PRESS_WAIT:
  - sync=0 -> IDLE; the bounce is rejected and no pulse is emitted.
  - Otherwise dcnt increments.
  - dcnt==DEBOUNCE_CYCLES-1 with sync=1 -> PRESSED, hold<=0.
- PRESSED:
  - btn_level_o=1.
  - press_pulse_o=1 in the first cycle only.
  - hold increments every cycle, saturating.
  - In the cycle after hold reaches LONG_PRESS_CYCLES-1, long_press_o=1 for exactly one cycle. It fires once per press and never refires while held.
  - sync=0 -> RELEASE_WAIT, dcnt<=0.
- RELEASE_WAIT:
  - btn_level_o stays 1 and hold keeps counting, since release bounce is still part of the press.
  - sync=1 -> PRESSED with hold preserved; no new press_pulse_o.
  - dcnt==DEBOUNCE_CYCLES-1 with sync=0 -> IDLE. release_pulse_o=1 for one cycle and btn_level_o=0 in that same cycle.
- Latency:
  - Count from the first clock edge that samples btn_raw_i high.
  - press_pulse_o asserts after DEBOUNCE_CYCLES+3 edges.
  - Release has the same latency from the first edge sampling low.
- All outputs are registered; there are no combinational paths from btn_raw_i to any output.
- hold_cycles_o:
  - Updates while in PRESSED or RELEASE_WAIT.
  - Holds its last value in IDLE until the next accepted press clears it.
- Simultaneous events:
  - If the long-press threshold is reached in the same cycle sync falls, long_press_o still pulses.
  - press_pulse_o, release_pulse_o and long_press_o are mutually exclusive within a cycle except for that long-press/fall case, in which the release pulse follows later anyway.
- Reset mid-operation:
  - Any in-flight pulse is cancelled immediately.
  - A button still held at reset deassertion is treated as a fresh press, so press_pulse_o fires DEBOUNCE_CYCLES+3 edges after release of reset.
- Counters are 32 bits. dcnt never exceeds DEBOUNCE_CYCLES-1, and hold never wraps.

Test Plan:
- Config: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10.
- Clean press: raise btn_raw_i and hold it -> press_pulse_o high for 1 cycle, 7 edges after the first sampling edge. btn_level_o=1 from that cycle on.
- Press bounce: toggle btn_raw_i high 2 cycles, low 1 cycle, then high steady -> no pulse during the glitch; a single press_pulse_o 7 edges after the final rise.
- Release bounce: while held, drop low 2 cycles, then high -> btn_level_o stays 1, no release_pulse_o, hold_cycles_o keeps counting. A later steady low -> one release_pulse_o 7 edges after the low is first sampled; btn_level_o=0.
- Long press: hold for 30 cycles -> exactly one long_press_o, 10 cycles after press_pulse_o. hold_cycles_o=30 at release entry.
- Reset mid-press: assert rst_ni=0 during PRESSED -> all outputs 0 immediately. Deassert with the button held -> new press_pulse_o 7 edges later.
- Active-low pad: set BTN_ACTIVE_LOW=1 and drive btn_raw_i=0 steady -> same timing as the clean press case.
